// File: rtl/count_event_monitor.sv
// Event monitor for the 32-bit up/down counter: detects LOAD, WRAP and MATCH events and queues them.
// Define COUNT_EVT_TSTAMP_EN to add a 16-bit cycle timestamp to each queued record.
module count_event_monitor #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DROP_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            count_in,
   input  logic                   load,
   input  logic                   mode,
   input  logic                   mon_en,
   input  logic [31:0]            cfg_match,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [1:0]             evt_type,
   output logic [31:0]            evt_value,
   output logic [$clog2(DEPTH):0] fifo_level,
`ifdef COUNT_EVT_TSTAMP_EN
   output logic [15:0]            evt_tstamp,
`endif
   output logic [DROP_W-1:0]      drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      EvtLoad   = 2'b00,
      EvtWrapUp = 2'b01,
      EvtWrapDn = 2'b10,
      EvtMatch  = 2'b11
   } evt_e;

   // Sampling history
   logic [31:0] prev;
   logic        prev_vld;
   logic        load_d;

   // FIFO state
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [1:0]        type_mem  [DEPTH];
   logic [31:0]       value_mem [DEPTH];
   logic [DROP_W-1:0] drop_q;

   // Event detection
   logic cand_load;
   logic cand_wrap_up;
   logic cand_wrap_dn;
   logic cand_match;
   logic evt_det;
   evt_e evt_sel;

   // FIFO control
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;

   always_comb begin
      cand_load    = load_d;
      cand_wrap_up = prev_vld && mode && (prev == 32'hFFFF_FFFF) && (count_in == 32'h0)
                     && !load_d;
      cand_wrap_dn = prev_vld && !mode && (prev == 32'h0) && (count_in == 32'hFFFF_FFFF)
                     && !load_d;
      // A value that is merely held does not re-trigger a match.
      cand_match   = (count_in == cfg_match) && (!prev_vld || (count_in != prev));
   end

   always_comb begin
      evt_sel = EvtMatch;
      evt_det = 1'b0;
      if (mon_en) begin
         if (cand_load) begin
            evt_sel = EvtLoad;
            evt_det = 1'b1;
         end else if (cand_wrap_up) begin
            evt_sel = EvtWrapUp;
            evt_det = 1'b1;
         end else if (cand_wrap_dn) begin
            evt_sel = EvtWrapDn;
            evt_det = 1'b1;
         end else if (cand_match) begin
            evt_sel = EvtMatch;
            evt_det = 1'b1;
         end
      end
   end

   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop   = !empty && evt_ready;
      // A pop in the same cycle frees the slot the push needs.
      push  = evt_det && (!full || pop);
      drop  = evt_det && full && !pop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev     <= 32'h0;
         prev_vld <= 1'b0;
         load_d   <= 1'b0;
      end else begin
         prev     <= count_in;
         prev_vld <= 1'b1;
         load_d   <= load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         drop_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
         end
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         type_mem[wr_ptr[AW-1:0]]  <= evt_sel;
         value_mem[wr_ptr[AW-1:0]] <= count_in;
      end
   end

`ifdef COUNT_EVT_TSTAMP_EN
   logic [15:0] cycle_cnt;
   logic [15:0] ts_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= 16'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ts_mem[wr_ptr[AW-1:0]] <= cycle_cnt;
      end
   end

   assign evt_tstamp = ts_mem[rd_ptr[AW-1:0]];
`endif

   assign evt_valid  = !empty;
   assign evt_type   = type_mem[rd_ptr[AW-1:0]];
   assign evt_value  = value_mem[rd_ptr[AW-1:0]];
   assign fifo_level = wr_ptr - rd_ptr;
   assign drop_cnt   = drop_q;

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream consumer of the 32-bit up/down counter. It samples the counter's `data_out` every clock alongside the `load` and `mode` controls driven into the counter. It detects load, wrap-around and match events and queues each as a record in a small FIFO. The records are drained over a valid/ready interface to the scoreboard or a host-side logger.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, 2..64.
- `DROP_W`, default 16: width of the saturating drop counter.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `count_in`, input, 32: counter `data_out`.
- `load`, input, 1: same signal driven to counter `load`.
- `mode`, input, 1: same signal driven to counter `mode`; 1 = up, 0 = down.
- `mon_en`, input, 1: event detection enable.
- `cfg_match`, input, 32: match value.
- `evt_valid`, output, 1: FIFO head holds a record.
- `evt_ready`, input, 1: consumer accepts the head.
- `evt_type`, output, 2: 00 LOAD, 01 WRAP_UP, 10 WRAP_DN, 11 MATCH.
- `evt_value`, output, 32: `count_in` value at the event.
- `fifo_level`, output, $clog2(DEPTH)+1: occupied entries.
- `drop_cnt`, output, DROP_W: events lost to a full FIFO; saturating.

## Operation
- Registers: `prev` (32), `prev_vld`, `load_d`, FIFO storage, write pointer, read pointer, `drop_cnt`.
- Update every edge, regardless of `mon_en`:
  - `prev <= count_in`
  - `prev_vld <= 1`
  - `load_d <= load`
- Candidate events in cycle k (combinational), all gated by `mon_en`:
  - LOAD: `load_d == 1`. The counter loads synchronously, so `count_in` already shows the loaded value.
  - WRAP_UP: `prev_vld`, `mode == 1`, `prev == 32'hFFFF_FFFF`, `count_in == 0`, `load_d == 0`.
  - WRAP_DN: `prev_vld`, `mode == 0`, `prev == 0`, `count_in == 32'hFFFF_FFFF`, `load_d == 0`.
  - MATCH: `count_in == cfg_match` and (`!prev_vld` or `count_in != prev`). A held value does not re-trigger.
- At most one record per cycle. Priority is LOAD > WRAP_UP/WRAP_DN > MATCH. Lower-priority candidates are discarded without counting as drops.
- Push: the record {type, `count_in`} is written at the end of cycle k if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the record is lost and `drop_cnt` increments, saturating at all-ones.
- Pop: occurs when `evt_valid && evt_ready`.
  - `evt_valid` = not empty.
  - `evt_type`/`evt_value` present the head combinationally from storage and are stable while `evt_valid && !evt_ready`.
- Push and pop in the same cycle:
  - When empty: no bypass; the record appears the next cycle.
  - Otherwise: level unchanged.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are decided by comparing the MSB and the remaining pointer bits.
- `mon_en` low: no pushes and no drops; pops continue. Reasserting `mon_en` does not replay missed events.
- Reset clears:
  - `prev` to 0 and `prev_vld` to 0
  - `load_d` to 0
  - both pointers and `drop_cnt` to 0
  - FIFO contents need not be cleared.
- Reset mid-operation discards all queued records immediately.

## Timing
- Reset values: `evt_valid` 0, `evt_type` don't-care while `evt_valid` is 0, `fifo_level` 0, `drop_cnt` 0.
- Latency: for an event detected from `count_in` in cycle k, `evt_valid` rises in cycle k+1 when the FIFO was empty.
- LOAD: `load` high in cycle k−1 gives a LOAD record in cycle k with `evt_value` = loaded data, visible in cycle k+1.
- Throughput: one push and one pop per cycle.
- `fifo_level` and `drop_cnt` update on the same edge as the push or pop.
- The first cycle after reset release never produces WRAP events (`prev_vld` is 0).

## Configuration
- `COUNT_EVT_TSTAMP_EN` defined:
  - Adds output port `evt_tstamp[15:0]`.
  - A 16-bit free-running cycle counter (reset 0, wraps at 16'hFFFF → 0) is captured into each FIFO entry at push.
  - `evt_tstamp` presents the head's capture.
- `COUNT_EVT_TSTAMP_EN` undefined: no timestamp port, counter or storage; behaviour otherwise identical.

## Test plan
- Load test: `load` with data 32'h0000_0010, mode up, `mon_en` 1, `evt_ready` 1.
  - Required: one LOAD record with value 32'h10, `evt_valid` 2 cycles after the `load` cycle; no other records.
- Up-wrap test: load 32'hFFFF_FFFE, count up.
  - Required: LOAD(FFFF_FFFE), then WRAP_UP with value 0 exactly two cycles later.
- Down-wrap test: load 32'h1, count down.
  - Required: LOAD(1), then WRAP_DN(FFFF_FFFF); no WRAP_UP ever.
- Match and priority test: `cfg_match` = 32'h20; load 32'h20.
  - Required: only LOAD(20) on that cycle (MATCH suppressed).
  - Then with `cfg_match` = 32'h25 and counting up from 32'h20: exactly one MATCH(25).
- Full/drop test, `DEPTH` = 8, `evt_ready` 0: generate 10 events.
  - Required: `fifo_level` 8, `drop_cnt` 2.
  - Raise `evt_ready`: 8 records drain in order, one per cycle, then `evt_valid` 0.
- Reset mid-queue: 3 records queued, assert `rst` asynchronously between edges.
  - Required: `evt_valid`, `fifo_level` and `drop_cnt` go to 0 immediately.
  - No WRAP record on the first post-reset sample, even if `count_in` = 0 after FFFF_FFFF.
